// File: rtl/values_load_unit.sv
// Operand/opcode capture bank: latches the switch value into operand A, operand B
// and the opcode register, each enabled by its own level-sensitive button.
module values_load_unit #(
    parameter int NB_INPUTS  = 8,
    parameter int NB_OUTPUTS = 8,
    parameter int NB_OP      = 6
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [2:0]            i_buttons,
    input  logic [NB_INPUTS-1:0]  i_switches,
    output logic [NB_OUTPUTS-1:0] o_data_a,
    output logic [NB_OUTPUTS-1:0] o_data_b,
    output logic [NB_OP-1:0]      o_operation
);

    logic [NB_OUTPUTS-1:0] switches_resized;
    logic [NB_OUTPUTS-1:0] operand_reg [2];
    logic [NB_OP-1:0]      operation_reg;

    // Operands are zero-extended when wider than the switch bus, truncated otherwise.
    generate
        if (NB_OUTPUTS > NB_INPUTS) begin : g_extend
            assign switches_resized = {{(NB_OUTPUTS - NB_INPUTS){1'b0}}, i_switches};
        end else begin : g_truncate
            assign switches_resized = i_switches[NB_OUTPUTS-1:0];
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_operand
            always_ff @(posedge i_clock) begin
                if (!i_reset) begin
                    operand_reg[gi] <= '0;
                end else if (i_buttons[gi]) begin
                    operand_reg[gi] <= switches_resized;
                end
            end
        end
    endgenerate

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            operation_reg <= '0;
        end else if (i_buttons[2]) begin
            operation_reg <= i_switches[NB_OP-1:0];
        end
    end

    assign o_data_a    = operand_reg[0];
    assign o_data_b    = operand_reg[1];
    assign o_operation = operation_reg;

endmodule

// File: tb/tb_values_load_unit.sv
// Randomized and directed checks of values_load_unit against a value-level model.
module tb_values_load_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] buttons;
    logic [7:0] switches;
    logic [7:0] data_a;
    logic [7:0] data_b;
    logic [5:0] operation;

    int errors = 0;
    int checks = 0;

    // Model state: what each register must hold after the latest edge.
    int  exp_a = 0;
    int  exp_b = 0;
    int  exp_op = 0;
    bit  model_valid = 1'b0;

    always #5 clk = ~clk;

    values_load_unit #(
        .NB_INPUTS (8),
        .NB_OUTPUTS(8),
        .NB_OP     (6)
    ) dut (
        .i_clock    (clk),
        .i_reset    (rst_n),
        .i_buttons  (buttons),
        .i_switches (switches),
        .o_data_a   (data_a),
        .o_data_b   (data_b),
        .o_operation(operation)
    );

    always @(posedge clk) begin
        if (rst_n === 1'b0) begin
            exp_a = 0;
            exp_b = 0;
            exp_op = 0;
            model_valid = 1'b1;
        end else begin
            if (buttons[0]) exp_a = int'(switches) % 256;
            if (buttons[1]) exp_b = int'(switches) % 256;
            if (buttons[2]) exp_op = int'(switches) % 64;
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (model_valid) begin
            chk("cycle_a", int'(data_a), exp_a);
            chk("cycle_b", int'(data_b), exp_b);
            chk("cycle_op", int'(operation), exp_op);
        end
    end

    // Apply inputs, let one rising edge take them, and return just after that edge.
    task automatic step(input logic r, input logic [2:0] b, input logic [7:0] s);
        rst_n = r;
        buttons = b;
        switches = s;
        @(posedge clk);
        #1;
        $display("step rst=%0b btn=%03b sw=%02h -> a=%02h b=%02h op=%02h",
                 r, b, s, data_a, data_b, operation);
    endtask

    initial begin
        // Reset with every button high.
        step(1'b0, 3'b111, 8'hFF);
        step(1'b0, 3'b111, 8'hFF);
        chk("reset_a", int'(data_a), 0);
        chk("reset_b", int'(data_b), 0);
        chk("reset_op", int'(operation), 0);

        // Individual loads.
        step(1'b1, 3'b001, 8'hFF);
        chk("load_a", int'(data_a), 'hFF);
        chk("load_a_b_clear", int'(data_b), 0);
        chk("load_a_op_clear", int'(operation), 0);
        step(1'b1, 3'b010, 8'hFF);
        chk("load_b", int'(data_b), 'hFF);
        step(1'b1, 3'b100, 8'hFF);
        chk("load_op", int'(operation), 'h3F);

        // Hold and opcode truncation.
        step(1'b1, 3'b001, 8'h5A);
        chk("load_a_5a", int'(data_a), 'h5A);
        for (int i = 0; i < 3; i++) step(1'b1, 3'b000, 8'hC3);
        chk("hold_a", int'(data_a), 'h5A);
        step(1'b1, 3'b100, 8'hC3);
        chk("trunc_op", int'(operation), 'h03);

        // Simultaneous load.
        step(1'b1, 3'b111, 8'h24);
        chk("simul_a", int'(data_a), 'h24);
        chk("simul_b", int'(data_b), 'h24);
        chk("simul_op", int'(operation), 'h24);

        // Reset mid-operation, then load on the first edge after release.
        step(1'b1, 3'b001, 8'h77);
        step(1'b0, 3'b001, 8'h77);
        chk("midrst_a", int'(data_a), 0);
        chk("midrst_b", int'(data_b), 0);
        chk("midrst_op", int'(operation), 0);
        step(1'b1, 3'b001, 8'h99);
        chk("release_a", int'(data_a), 'h99);
        chk("release_b", int'(data_b), 0);

        // Tracking while the button is held.
        for (int v = 1; v <= 3; v++) begin
            step(1'b1, 3'b010, 8'(v));
            chk("track_b", int'(data_b), v);
        end

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 19) == 0) ? 1'b0 : 1'b1,
                 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
        end

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
